param_bubble_sorter: RTL and testbench

Self-contained, parametrised sorting engine: buffers up to DEPTH words, sorts them in place with an early-terminating bubble sort, then streams them out.
Successor to the fixed-function sorter control unit. Folds control and datapath into one block and adds:
- generic width and depth
- runtime ascending/descending mode
- partial loads
- valid/ready streaming on both sides
- swap statistics
Sits between an upstream producer (switches/host) and a display or result consumer.

---
 rtl/sorter_pkg.sv | 15 +
 rtl/param_bubble_sorter_cmp_swap.sv | 23 ++
 rtl/param_bubble_sorter.sv | 142 ++++++++++++++
 tb/tb_param_bubble_sorter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared encodings for the parametrised bubble sorter: FSM states, sort
// direction codes and the width of the swap statistics counter.
package sorter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SORT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic MODE_ASC  = 1'b0;
  localparam logic MODE_DESC = 1'b1;

  localparam int SWAP_CNT_W = 16;

endpackage

// File: rtl/param_bubble_sorter_cmp_swap.sv
// Compare-and-swap cell: orders one adjacent pair for the selected direction.
// lo_out lands at the lower address, hi_out at the higher one.
module cmp_swap
  import sorter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swap
);

  // Strict comparisons keep equal words in place, which makes the sort stable.
  always_comb begin
    swap   = (mode == MODE_ASC) ? (a > b) : (a < b);
    lo_out = swap ? b : a;
    hi_out = swap ? a : b;
  end

endmodule

// File: rtl/param_bubble_sorter.sv
// Buffers up to DEPTH words, bubble-sorts them in place with early exit,
// then streams the sorted words out over a valid/ready interface.
module param_bubble_sorter
  import sorter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_cnt
);

  localparam int IDXW = $clog2(DEPTH);

  logic [1:0]       state;
  logic [CNTW-1:0]  n;
  logic [CNTW-1:0]  n_inc;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_nxt;
  logic [IDXW-1:0]  limit;
  logic [IDXW-1:0]  rd;
  logic             swapped;
  logic             mode_r;
  logic             accept;
  logic             out_hs;
  logic             last_word;
  logic             last_rd;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             swap;
  logic [WIDTH-1:0] mem [DEPTH];

  assign in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign out_valid = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign out_data  = mem[rd];
  assign last_rd   = (rd == IDXW'(n - 1'b1));
  assign out_last  = out_valid && last_rd;

  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign n_inc     = n + 1'b1;
  assign last_word = in_last || (n_inc == CNTW'(DEPTH));
  assign idx_nxt   = idx + 1'b1;

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a      (mem[idx]),
    .b      (mem[idx_nxt]),
    .mode   (mode_r),
    .lo_out (lo),
    .hi_out (hi),
    .swap   (swap)
  );

  // Storage is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[IDXW'(n)] <= in_data;
    end else if (state == ST_SORT && swap) begin
      mem[idx]     <= lo;
      mem[idx_nxt] <= hi;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      n        <= '0;
      idx      <= '0;
      limit    <= '0;
      rd       <= '0;
      swapped  <= 1'b0;
      mode_r   <= MODE_ASC;
      done     <= 1'b0;
      swap_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            n <= n_inc;
            if (state == ST_IDLE) begin
              mode_r   <= mode;
              swap_cnt <= '0;
            end
            // limit takes the new count minus one, which is the old count.
            if (last_word) begin
              idx     <= '0;
              limit   <= IDXW'(n);
              swapped <= 1'b0;
              rd      <= '0;
              state   <= (n == '0) ? ST_DRAIN : ST_SORT;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_SORT: begin
          if (swap) begin
            swapped <= 1'b1;
            if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
          end
          if (idx != limit - 1'b1) begin
            idx <= idx_nxt;
          end else if (!(swapped || swap) || limit == IDXW'(1)) begin
            state <= ST_DRAIN;
          end else begin
            limit   <= limit - 1'b1;
            idx     <= '0;
            swapped <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (out_hs) begin
            if (last_rd) begin
              state <= ST_IDLE;
              done  <= 1'b1;
              n     <= '0;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_bubble_sorter.sv
// Self-checking bench for param_bubble_sorter: directed and random loads are
// compared against a queue-sort / inversion-count reference model.
module tb_param_bubble_sorter;
  import sorter_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  typedef logic [WIDTH-1:0] word_q_t [$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [15:0]      swap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_bubble_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .swap_cnt  (swap_cnt)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mode flips after the first word so that only the latched value may matter.
  task automatic apply_stimulus(input word_q_t data, input logic m, input bit use_last);
    for (int i = 0; i < data.size(); i++) begin
      int waitc;
      waitc    = 0;
      in_valid = 1'b1;
      in_data  = data[i];
      in_last  = use_last && (i == data.size() - 1);
      mode     = (i == 0) ? m : ~m;
      while (!in_ready && waitc < 20) begin
        step();
        waitc++;
      end
      if (!in_ready) begin
        check("load_timeout", in_ready, 1);
        break;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    mode     = 1'b0;
  endtask

  task automatic count_sort(output int cyc);
    cyc = 0;
    while (busy && !out_valid && cyc < 300) begin
      check("sort_in_ready", in_ready, 0);
      step();
      cyc++;
    end
    check("sort_reaches_drain", out_valid, 1);
  endtask

  task automatic check_output(input string tag, input word_q_t exp, input int stall);
    int k;
    int cyc;
    bit hs;
    k   = 0;
    cyc = 0;
    while (k < exp.size() && cyc < 400) begin
      case (stall)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp[k]);
      check({tag, "_last"}, out_last, k == exp.size() - 1);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_done_early"}, done, 0);
      hs = out_valid && out_ready;
      step();
      cyc++;
      if (hs) k++;
    end
    check({tag, "_drain_count"}, k, exp.size());
    out_ready = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_in_ready_after"}, in_ready, 1);
    check({tag, "_valid_after"}, out_valid, 0);
    step();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic run_case(input string tag, input word_q_t data, input logic m,
                          input bit use_last, input int stall, input int exp_cyc);
    word_q_t exp;
    int cyc;
    int inv;
    int n;
    n   = data.size();
    exp = data;
    if (m) exp.rsort();
    else   exp.sort();
    inv = 0;
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (m ? (data[i] < data[j]) : (data[i] > data[j])) inv++;
    apply_stimulus(data, m, use_last);
    count_sort(cyc);
    if (exp_cyc >= 0) check({tag, "_sort_cycles"}, cyc, exp_cyc);
    else              check({tag, "_sort_bound"}, cyc <= n * (n - 1) / 2, 1);
    check({tag, "_swap_cnt"}, swap_cnt, inv);
    check_output(tag, exp, stall);
    check({tag, "_swap_hold"}, swap_cnt, inv);
  endtask

  initial begin
    word_q_t d;
    int n;
    $display("[TB] start");
    rst_n = 1'b0;
    step();
    step();
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_done", done, 0);
    check("reset_swap_cnt", swap_cnt, 0);
    rst_n = 1'b1;
    step();

    d = '{8'd3, 8'd1, 8'd2, 8'd0};
    run_case("asc4", d, MODE_ASC, 1'b1, 0, -1);
    run_case("desc4", d, MODE_DESC, 1'b1, 0, -1);

    d = {};
    for (int i = 0; i < 8; i++) d.push_back(8'(i));
    run_case("sorted8", d, MODE_ASC, 1'b0, 0, 7);

    d = {};
    for (int i = 7; i >= 0; i--) d.push_back(8'(i));
    run_case("reverse8", d, MODE_ASC, 1'b1, 0, 28);

    d = '{8'd5};
    run_case("single", d, MODE_ASC, 1'b1, 0, 0);

    d = '{8'd2, 8'd2, 8'd1};
    run_case("stable3", d, MODE_ASC, 1'b1, 0, -1);

    d = '{8'd6, 8'd3, 8'd8, 8'd1, 8'd7};
    run_case("stall5", d, MODE_DESC, 1'b1, 1, -1);

    for (int r = 0; r < 8; r++) begin
      bit m;
      bit lst;
      n = $urandom_range(1, DEPTH);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
      m   = 1'($urandom_range(0, 1));
      lst = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      run_case($sformatf("rand%0d", r), d, m, lst, 2, -1);
    end

    d = {};
    for (int i = 7; i >= 0; i--) d.push_back(8'(i));
    apply_stimulus(d, MODE_ASC, 1'b0);
    step();
    step();
    check("mid_sort_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_swap_cnt", swap_cnt, 0);
    check("abort_done", done, 0);

    d = '{8'd9, 8'd4};
    run_case("after_reset", d, MODE_ASC, 1'b1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
